nx_rfb_fifo_ctrl: RTL and testbench
===================================

// Module: nx_rfb_fifo_ctrl
// PURPOSE
//  FIFO controller that sits directly in front of an NX_RFB_U register-file primitive.
//  It turns an NX_RFB_U into a first-word-fall-through (FWFT) synchronous FIFO with
//  valid/ready handshakes on both sides.
//  It generates the write enable, write address and read address, and pads data to the
//  RFB's 36-bit port.
//  It returns the RFB's asynchronous read data as the FIFO head.
//  Used by RAM inference wherever a small shallow FIFO maps onto one RFB.
// PARAMETERS
//  RFB_MODE       0   NX_RFB_U mode driven. 0 = 32x18, 2 = 64x18, 3 = 32x36.
//                     Modes 1 and 4 -> $error.
//  AFULL_THRESH   DEPTH-2   almost_full asserts when count >= this.
//  AEMPTY_THRESH  1         almost_empty asserts when count <= this.
//  Derived:       DEPTH  = (RFB_MODE==2) ? 64 : 32
//                 WIDTH  = (RFB_MODE==3) ? 36 : 18
//                 ADDR_W = (RFB_MODE==2) ? 6 : 5
// PORTS
//  clock         in   1         clock; all state updates on its rising edge
//  async_reset   in   1         reset, asynchronous, active-high
//  flush         in   1         synchronous clear of FIFO contents
//  in_valid      in   1         write-side data valid
//  in_ready      out  1         write-side ready (FIFO not full)
//  in_data       in   WIDTH     write data
//  out_valid     out  1         head word valid (FIFO not empty)
//  out_ready     in   1         consumer accepts head word
//  out_data      out  WIDTH     head word = rfb_o[WIDTH-1:0]
//  count         out  ADDR_W+1  current occupancy, 0..DEPTH
//  almost_full   out  1         count >= AFULL_THRESH
//  almost_empty  out  1         count <= AEMPTY_THRESH
//  rfb_we        out  1         to NX_RFB_U WE
//  rfb_wa        out  6         to WA6..WA1 (wr_ptr, zero-extended)
//  rfb_ra        out  6         to RA6..RA1 (rd_ptr, zero-extended)
//  rfb_i         out  36        to I36..I1 (in_data, zero-extended)
//  rfb_o         in   36        from O36..O1 (combinational read of RA)
// BEHAVIOUR
//  State: wr_ptr, rd_ptr (ADDR_W bits, wrap DEPTH-1 -> 0 naturally) and count (ADDR_W+1 bits).
//  async_reset: wr_ptr = rd_ptr = count = 0 immediately.
//   Outputs under reset: in_ready=1, out_valid=0, almost_empty=1, almost_full=0, rfb_we=0.
//  full = (count==DEPTH); empty = (count==0).
//  Combinational outputs:
//   in_ready  = !full && !flush
//   out_valid = !empty && !flush
//  push = in_valid && in_ready; pop = out_valid && out_ready.
//  rfb_we = push.
//   The RFB captures in_data at mem[wr_ptr] on the same edge that advances wr_ptr.
//  Edge update:
//   - flush: pointers and count -> 0; any push/pop that cycle is dropped (memory untouched).
//   - push only: wr_ptr+1, count+1.
//   - pop only: rd_ptr+1, count-1.
//   - push & pop: both pointers +1, count unchanged.
//     This is legal at any 0<count<DEPTH (no read-during-write hazard, since wr_ptr != rd_ptr).
//   - Full: no push. Empty: no pop. There is no write-to-read bypass when empty.
//  Latency: a word pushed at edge N is visible on out_data with out_valid=1 in the cycle after N.
//   Minimum fall-through is one cycle.
//  out_data is stable while out_valid=1 and out_ready=0. The head never changes without a pop.
//  RFB instance must be configured wck_edge=0 and mode=RFB_MODE.
//   RFB memory content after reset is don't-care; out_valid gates it.
//  Reset asserted mid-transfer: all in-flight words are discarded. No partial pointer updates.
//  Threshold outputs are derived combinationally from the registered count.
// STRUCTURE
//  Shared package nx_rfb_pkg holds:
//   - functions rfb_depth(mode), rfb_width(mode), rfb_addr_w(mode)
//   - localparam RFB_PORT_W = 36
//   The NX_RFB_U sim model and the RAM mapping rules reuse the same package.
//  No sub-module: single always block for pointers/count, plus combinational assigns.
//  The NX_RFB_U itself is instantiated by the parent, not inside this block.
// TESTING (bench instantiates this block + NX_RFB_U)
//  1. Reset, then push 0x00001..0x00005 back-to-back (mode 0)
//     -> out_valid rises 1 cycle after first push; pops return 1..5 in order;
//        count goes 5 -> 0; almost_empty=1 at count<=1.
//  2. Fill mode 0 with 32 words, holding in_valid=1
//     -> in_ready=0 at count=32; 33rd word not written (rfb_we=0);
//        almost_full=1 from count=30.
//  3. At count=16, hold in_valid=out_ready=1 for 100 cycles
//     -> count stays 16; pointers wrap; data order preserved across wrap.
//  4. flush asserted at count=10 while push and pop are both requested
//     -> next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle word is lost.
//  5. async_reset pulsed mid-stream between edges (mode 2, count=40)
//     -> count=0 and out_valid=0 immediately; afterwards a 64-deep fill succeeds.
//  6. Mode 3: push 0xA_BCDE_F012 (36 bit) -> out_data identical; rfb_i upper bits not truncated.

Source files
------------

// File: rtl/nx_rfb_pkg.sv
// Shared NX_RFB_U geometry helpers, used by the FIFO controller, the RFB sim model and RAM mapping.
// Mode encoding: 0 = 32x18, 2 = 64x18, 3 = 32x36; modes 1 and 4 are not supported here.
package nx_rfb_pkg;

   localparam int unsigned RFB_PORT_W = 36;

   function automatic int unsigned rfb_depth(input int unsigned mode);
      return (mode == 2) ? 64 : 32;
   endfunction

   function automatic int unsigned rfb_width(input int unsigned mode);
      return (mode == 3) ? 36 : 18;
   endfunction

   function automatic int unsigned rfb_addr_w(input int unsigned mode);
      return (mode == 2) ? 6 : 5;
   endfunction

   function automatic bit rfb_mode_ok(input int unsigned mode);
      return (mode == 0) || (mode == 2) || (mode == 3);
   endfunction

endpackage

// File: rtl/nx_rfb_fifo_ctrl.sv
// FWFT FIFO controller wrapped around an external NX_RFB_U: owns pointers and occupancy,
// drives the RFB write port and read address, and presents the asynchronous read data as the head.
module nx_rfb_fifo_ctrl
   import nx_rfb_pkg::*;
#(
   parameter int unsigned RFB_MODE      = 0,
   parameter int unsigned AFULL_THRESH  = rfb_depth(RFB_MODE) - 2,
   parameter int unsigned AEMPTY_THRESH = 1
) (
   input  logic                                  clock,
   input  logic                                  async_reset,
   input  logic                                  flush,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [rfb_width(RFB_MODE)-1:0]        in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [rfb_width(RFB_MODE)-1:0]        out_data,
   output logic [rfb_addr_w(RFB_MODE):0]         count,
   output logic                                  almost_full,
   output logic                                  almost_empty,
   output logic                                  rfb_we,
   output logic [5:0]                            rfb_wa,
   output logic [5:0]                            rfb_ra,
   output logic [RFB_PORT_W-1:0]                 rfb_i,
   input  logic [RFB_PORT_W-1:0]                 rfb_o
);

   localparam int unsigned DEPTH  = rfb_depth(RFB_MODE);
   localparam int unsigned WIDTH  = rfb_width(RFB_MODE);
   localparam int unsigned ADDR_W = rfb_addr_w(RFB_MODE);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   if (!rfb_mode_ok(RFB_MODE)) begin : g_bad_mode
      $error("nx_rfb_fifo_ctrl: RFB_MODE %0d is not supported", RFB_MODE);
   end

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic full, empty, push, pop;
   logic unused_rfb_o;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // flush blocks both handshakes so nothing is accepted in the cycle being cleared
   assign in_ready  = !full && !flush;
   assign out_valid = !empty && !flush;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge async_reset) begin
      if (async_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count        = count_q;
   assign almost_full  = 32'(count_q) >= AFULL_THRESH;
   assign almost_empty = 32'(count_q) <= AEMPTY_THRESH;

   // RFB writes mem[wr_ptr] on the same edge that advances wr_ptr
   assign rfb_we = push;
   assign rfb_wa = 6'(wr_ptr_q);
   assign rfb_ra = 6'(rd_ptr_q);
   assign rfb_i  = RFB_PORT_W'(in_data);

   assign out_data     = rfb_o[WIDTH-1:0];
   assign unused_rfb_o = ^rfb_o;

endmodule

// File: tb/tb_nx_rfb_fifo_ctrl.sv
// Directed bench: three controller instances (modes 0, 2, 3), each with a behavioural RFB.
module tb_nx_rfb_fifo_ctrl;

   logic clock = 1'b0;
   logic async_reset = 1'b1;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // ---------------- mode 0 instance (32x18) ----------------
   logic        flush0 = 0, in_valid0 = 0, out_ready0 = 0;
   logic [17:0] in_data0 = '0, out_data0;
   logic        in_ready0, out_valid0, afull0, aempty0, rfb_we0;
   logic [5:0]  count0, rfb_wa0, rfb_ra0;
   logic [35:0] rfb_i0, rfb_o0;
   logic [35:0] mem0 [64];

   always @(posedge clock) if (rfb_we0) mem0[rfb_wa0] <= rfb_i0;
   assign rfb_o0 = mem0[rfb_ra0];

   nx_rfb_fifo_ctrl #(.RFB_MODE(0)) u_dut0 (
      .clock(clock), .async_reset(async_reset), .flush(flush0),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .count(count0), .almost_full(afull0), .almost_empty(aempty0),
      .rfb_we(rfb_we0), .rfb_wa(rfb_wa0), .rfb_ra(rfb_ra0), .rfb_i(rfb_i0), .rfb_o(rfb_o0)
   );

   // ---------------- mode 2 instance (64x18) ----------------
   logic        flush2 = 0, in_valid2 = 0, out_ready2 = 0;
   logic [17:0] in_data2 = '0, out_data2;
   logic        in_ready2, out_valid2, afull2, aempty2, rfb_we2;
   logic [6:0]  count2;
   logic [5:0]  rfb_wa2, rfb_ra2;
   logic [35:0] rfb_i2, rfb_o2;
   logic [35:0] mem2 [64];

   always @(posedge clock) if (rfb_we2) mem2[rfb_wa2] <= rfb_i2;
   assign rfb_o2 = mem2[rfb_ra2];

   nx_rfb_fifo_ctrl #(.RFB_MODE(2)) u_dut2 (
      .clock(clock), .async_reset(async_reset), .flush(flush2),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .count(count2), .almost_full(afull2), .almost_empty(aempty2),
      .rfb_we(rfb_we2), .rfb_wa(rfb_wa2), .rfb_ra(rfb_ra2), .rfb_i(rfb_i2), .rfb_o(rfb_o2)
   );

   // ---------------- mode 3 instance (32x36) ----------------
   logic        flush3 = 0, in_valid3 = 0, out_ready3 = 0;
   logic [35:0] in_data3 = '0, out_data3;
   logic        in_ready3, out_valid3, afull3, aempty3, rfb_we3;
   logic [5:0]  count3, rfb_wa3, rfb_ra3;
   logic [35:0] rfb_i3, rfb_o3;
   logic [35:0] mem3 [64];

   always @(posedge clock) if (rfb_we3) mem3[rfb_wa3] <= rfb_i3;
   assign rfb_o3 = mem3[rfb_ra3];

   nx_rfb_fifo_ctrl #(.RFB_MODE(3)) u_dut3 (
      .clock(clock), .async_reset(async_reset), .flush(flush3),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .count(count3), .almost_full(afull3), .almost_empty(aempty3),
      .rfb_we(rfb_we3), .rfb_wa(rfb_wa3), .rfb_ra(rfb_ra3), .rfb_i(rfb_i3), .rfb_o(rfb_o3)
   );

   // Pops n words from dut0, expecting base, base+1, ...
   task automatic drain0(input int n, input int base);
      out_ready0 = 1;
      for (int k = 0; k < n; k++) begin
         #1;
         check_val("t_drain0_valid", 64'(out_valid0), 64'd1);
         check_val("t_drain0_data", 64'(out_data0), 64'(base + k));
         check_val("t_drain0_count", 64'(count0), 64'(n - k));
         step();
      end
      out_ready0 = 0;
      #1;
      check_val("t_drain0_empty", 64'(out_valid0), 64'd0);
      check_val("t_drain0_cnt0", 64'(count0), 64'd0);
   endtask

   task automatic fill0(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         in_valid0 = 1;
         in_data0  = 18'(base + k);
         step();
      end
      in_valid0 = 0;
   endtask

   initial begin
      // reset state
      #1;
      check_val("rst_in_ready", 64'(in_ready0), 64'd1);
      check_val("rst_out_valid", 64'(out_valid0), 64'd0);
      check_val("rst_aempty", 64'(aempty0), 64'd1);
      check_val("rst_afull", 64'(afull0), 64'd0);
      check_val("rst_we", 64'(rfb_we0), 64'd0);
      check_val("rst_count", 64'(count0), 64'd0);
      #10 async_reset = 0;
      step();

      // 1: push 1..5 back-to-back, then pop in order
      for (int i = 1; i <= 5; i++) begin
         in_valid0 = 1;
         in_data0  = 18'(i);
         #1;
         check_val("t1_we", 64'(rfb_we0), 64'd1);
         check_val("t1_wa", 64'(rfb_wa0), 64'(i - 1));
         check_val("t1_rfb_i", 64'(rfb_i0), 64'(i));
         if (i == 1) check_val("t1_no_early_valid", 64'(out_valid0), 64'd0);
         step();
         if (i == 1) begin
            check_val("t1_valid_after_1", 64'(out_valid0), 64'd1);
            check_val("t1_head_after_1", 64'(out_data0), 64'd1);
         end
      end
      in_valid0 = 0;
      #1;
      check_val("t1_count5", 64'(count0), 64'd5);
      check_val("t1_aempty5", 64'(aempty0), 64'd0);
      out_ready0 = 1;
      for (int i = 1; i <= 5; i++) begin
         #1;
         check_val("t1_pop_data", 64'(out_data0), 64'(i));
         check_val("t1_pop_count", 64'(count0), 64'(6 - i));
         check_val("t1_pop_aempty", 64'(aempty0), 64'((6 - i) <= 1));
         step();
      end
      out_ready0 = 0;
      #1;
      check_val("t1_end_count", 64'(count0), 64'd0);
      check_val("t1_end_valid", 64'(out_valid0), 64'd0);

      // 2: fill to 32 holding in_valid; 33rd word refused
      for (int i = 0; i <= 32; i++) begin
         int exp_cnt;
         exp_cnt   = (i < 32) ? i : 32;
         in_valid0 = 1;
         in_data0  = 18'(100 + i);
         #1;
         check_val("t2_count", 64'(count0), 64'(exp_cnt));
         check_val("t2_in_ready", 64'(in_ready0), 64'(exp_cnt < 32));
         check_val("t2_we", 64'(rfb_we0), 64'(exp_cnt < 32));
         check_val("t2_afull", 64'(afull0), 64'(exp_cnt >= 30));
         if (i > 0) check_val("t2_head_stable", 64'(out_data0), 64'd100);
         step();
      end
      in_valid0 = 0;
      drain0(32, 100);

      // 3: steady push+pop at count 16 for 100 cycles, across pointer wrap
      fill0(16, 200);
      in_valid0  = 1;
      out_ready0 = 1;
      for (int c = 0; c < 100; c++) begin
         in_data0 = 18'(216 + c);
         #1;
         check_val("t3_data", 64'(out_data0), 64'(200 + c));
         check_val("t3_count", 64'(count0), 64'd16);
         step();
      end
      in_valid0  = 0;
      out_ready0 = 0;
      drain0(16, 300);

      // 4: flush at count 10 with push and pop requested
      fill0(10, 400);
      in_valid0  = 1;
      in_data0   = 18'h3e7;
      out_ready0 = 1;
      flush0     = 1;
      #1;
      check_val("t4_flush_in_ready", 64'(in_ready0), 64'd0);
      check_val("t4_flush_valid", 64'(out_valid0), 64'd0);
      check_val("t4_flush_we", 64'(rfb_we0), 64'd0);
      step();
      flush0     = 0;
      in_valid0  = 0;
      out_ready0 = 0;
      #1;
      check_val("t4_count", 64'(count0), 64'd0);
      check_val("t4_valid", 64'(out_valid0), 64'd0);
      check_val("t4_in_ready", 64'(in_ready0), 64'd1);
      fill0(1, 777);
      drain0(1, 777);

      // 5: async reset pulse between edges at count 40 (mode 2)
      for (int k = 0; k < 40; k++) begin
         in_valid2 = 1;
         in_data2  = 18'(k);
         step();
      end
      in_valid2 = 0;
      check_val("t5_count40", 64'(count2), 64'd40);
      async_reset = 1;
      #1;
      check_val("t5_rst_count", 64'(count2), 64'd0);
      check_val("t5_rst_valid", 64'(out_valid2), 64'd0);
      #1 async_reset = 0;
      step();
      for (int k = 0; k < 64; k++) begin
         in_valid2 = 1;
         in_data2  = 18'(500 + k);
         #1;
         check_val("t5_fill_ready", 64'(in_ready2), 64'd1);
         step();
      end
      in_valid2 = 0;
      #1;
      check_val("t5_full_count", 64'(count2), 64'd64);
      check_val("t5_full_ready", 64'(in_ready2), 64'd0);
      check_val("t5_full_afull", 64'(afull2), 64'd1);
      out_ready2 = 1;
      for (int k = 0; k < 64; k++) begin
         #1;
         check_val("t5_drain", 64'(out_data2), 64'(500 + k));
         step();
      end
      out_ready2 = 0;
      #1;
      check_val("t5_end_valid", 64'(out_valid2), 64'd0);
      check_val("t5_end_aempty", 64'(aempty2), 64'd1);

      // 6: full 36-bit word through mode 3
      in_valid3 = 1;
      in_data3  = 36'hA_BCDE_F012;
      #1;
      check_val("t6_rfb_i", 64'(rfb_i3), 64'hA_BCDE_F012);
      check_val("t6_we", 64'(rfb_we3), 64'd1);
      step();
      in_valid3 = 0;
      #1;
      check_val("t6_valid", 64'(out_valid3), 64'd1);
      check_val("t6_data", 64'(out_data3), 64'hA_BCDE_F012);
      check_val("t6_count", 64'(count3), 64'd1);
      out_ready3 = 1;
      step();
      out_ready3 = 0;
      #1;
      check_val("t6_empty", 64'(out_valid3), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
